// File: rtl/exec_alu_unit.sv
// rtl/exec_alu_unit.sv - registered ALU with valid/ready handshake
// Define EXEC_ALU_MUL_EN to build the iterative shift-add multiplier (BUSY state).
module exec_alu_unit #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [10:0]  funct,
  input  logic [1:0]   aluop,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         illegal
);

`ifdef EXEC_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_PASS, OP_MUL, OP_ILL
  } op_t;

  state_t       state, state_nx;
  op_t          op;
  logic [N-1:0] alu_res;
  logic         accept;
  logic         mul_last;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Decode order matters: the first matching row wins.
  always_comb begin
    op = OP_ILL;
    if (aluop == 2'b00) begin
      op = OP_ADD;
    end else if (aluop == 2'b01) begin
      if (funct[10:3] == 8'b10110100 || funct[10:3] == 8'b10110101)
        op = OP_PASS;
    end else begin
      if (funct == 11'b10001011000)
        op = OP_ADD;
      else if (funct == 11'b11001011000)
        op = OP_SUB;
      else if (funct == 11'b10001010000)
        op = OP_AND;
      else if (funct == 11'b10101010000)
        op = OP_ORR;
      else if (funct[10:1] == 10'b1001000100)
        op = OP_ADD;
      else if (funct == 11'b10011011000) begin
`ifdef EXEC_ALU_MUL_EN
        op = OP_MUL;
`else
        op = OP_ILL;
`endif
      end
    end
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      OP_PASS: alu_res = b;
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_ALU_MUL_EN
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;
  logic [N-1:0]  acc, acc_nx, mcand, mplier;

  assign acc_nx   = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(N - 1));

  // One multiplier bit per BUSY cycle; operands are latched so input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept && op == OP_MUL) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (state == BUSY) begin
      cnt    <= cnt + CW'(1);
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign mul_last = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
`ifdef EXEC_ALU_MUL_EN
          state_nx = (op == OP_MUL) ? BUSY : DONE;
`else
          state_nx = DONE;
`endif
        end else if (state == DONE && out_ready) begin
          state_nx = IDLE;
        end
      end
`ifdef EXEC_ALU_MUL_EN
      BUSY: begin
        if (mul_last)
          state_nx = DONE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Output registers only change on a new accept or multiplier completion, so DONE holds them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (accept && op != OP_MUL) begin
      result  <= alu_res;
      zero    <= (alu_res == '0);
      illegal <= (op == OP_ILL);
    end
`ifdef EXEC_ALU_MUL_EN
    else if (state == BUSY && mul_last) begin
      result  <= acc_nx;
      zero    <= (acc_nx == '0);
      illegal <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_exec_alu_unit.sv
// tb/tb_exec_alu_unit.sv - self-checking bench for exec_alu_unit
// Define EXEC_ALU_MUL_EN to also exercise the multiplier path.
`timescale 1ns/1ps
module tb_exec_alu_unit;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [10:0]  funct;
  logic [1:0]   aluop;
  logic [N-1:0] a, b, result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_alu_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .aluop(aluop), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  typedef struct packed {
    logic [N-1:0] r;
    logic         z;
    logic         ill;
  } exp_t;

  typedef struct {
    logic [1:0]   al;
    logic [10:0]  f;
    logic [N-1:0] x, y, r;
    logic         z, ill;
  } vec_t;

  localparam int NV = 10;
  vec_t vt[NV];
  exp_t q[$];
  logic [10:0] fl[8];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from the decode table, using plain arithmetic.
  function automatic exp_t model(input logic [1:0] al, input logic [10:0] f,
                                 input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    e.r   = '0;
    e.ill = 1'b0;
    if (al == 2'b00)
      e.r = x + y;
    else if (al == 2'b01) begin
      if (f[10:4] == 7'b1011010) e.r = y;
      else e.ill = 1'b1;
    end else if (f == 11'b10001011000 || f[10:1] == 10'b1001000100)
      e.r = x + y;
    else if (f == 11'b11001011000)
      e.r = x - y;
    else if (f == 11'b10001010000)
      e.r = x & y;
    else if (f == 11'b10101010000)
      e.r = x | y;
    else if (f == 11'b10011011000) begin
`ifdef EXEC_ALU_MUL_EN
      e.r = x * y;
`else
      e.ill = 1'b1;
`endif
    end else
      e.ill = 1'b1;
    e.z = (e.r == '0);
    return e;
  endfunction

  initial begin
    logic [N-1:0] ex;
    exp_t e;
    int pushes, pops, spurious, cnt;

    vt[0] = '{2'b10, 11'b11001011000, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vt[1] = '{2'b01, 11'b10110100000, 64'd9, 64'd0, 64'd0, 1'b1, 1'b0};
    vt[2] = '{2'b01, 11'b10110101011, 64'd9, 64'd3, 64'd3, 1'b0, 1'b0};
    vt[3] = '{2'b10, 11'b11111111111, 64'd5, 64'd7, 64'd0, 1'b1, 1'b1};
    vt[4] = '{2'b00, 11'b11111111111, 64'd10, 64'd20, 64'd30, 1'b0, 1'b0};
    vt[5] = '{2'b10, 11'b10001010000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0};
    vt[6] = '{2'b11, 11'b10101010000, 64'h00F0, 64'h000F, 64'h00FF, 1'b0, 1'b0};
    vt[7] = '{2'b10, 11'b10010001001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0};
    vt[8] = '{2'b11, 11'b10001011000, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0};
    vt[9] = '{2'b01, 11'b10001011000, 64'd1, 64'd2, 64'd0, 1'b1, 1'b1};
    fl = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
           11'b10010001000, 11'b10011011000, 11'b10110100111, 11'b10110101000};

    // Reset state
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    funct = '0; aluop = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst zero", zero, 0);
    check("rst illegal", illegal, 0);
    reset = 1'b0;
    #1;
    check("rst in_ready", in_ready, 1);

    // Table vectors, latency 1
    out_ready = 1'b1;
    tick;
    for (int i = 0; i < NV; i++) begin
      aluop = vt[i].al; funct = vt[i].f; a = vt[i].x; b = vt[i].y; in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", i), in_ready, 1);
      tick;
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d result", i), result, vt[i].r);
      check($sformatf("vec%0d zero", i), zero, vt[i].z);
      check($sformatf("vec%0d illegal", i), illegal, vt[i].ill);
      tick;
    end

    // Four back-to-back ADDs
    aluop = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 64'(k * 11 + 1); b = 64'(k * 3);
      ex = a + b;
      #1;
      check($sformatf("b2b%0d in_ready", k), in_ready, 1);
      tick;
      check($sformatf("b2b%0d out_valid", k), out_valid, 1);
      check($sformatf("b2b%0d result", k), result, ex);
    end
    in_valid = 1'b0;
    tick;
    check("b2b idle", out_valid, 0);

    // Back-pressure holds the first result
    out_ready = 1'b0; in_valid = 1'b1; a = 64'd100; b = 64'd1;
    tick;
    a = 64'd7; b = 64'd7;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d in_ready", k), in_ready, 0);
      check($sformatf("hold%0d out_valid", k), out_valid, 1);
      check($sformatf("hold%0d result", k), result, 101);
      tick;
    end
    out_ready = 1'b1;
    #1;
    check("hold release in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("hold next result", result, 14);
    check("hold next out_valid", out_valid, 1);
    tick;
    check("hold drain", out_valid, 0);

    // Asynchronous reset while a result is pending
    out_ready = 1'b0; in_valid = 1'b1; a = 64'd1; b = 64'd1;
    tick;
    in_valid = 1'b0;
    check("arst pre out_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("arst out_valid", out_valid, 0);
    check("arst result", result, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("arst in_ready", in_ready, 1);
    tick;
    check("arst no out_valid", out_valid, 0);

`ifdef EXEC_ALU_MUL_EN
    // Multiplier: N busy cycles then result
    out_ready = 1'b1; aluop = 2'b10; funct = 11'b10011011000;
    a = 64'h1_0000_0001; b = 64'h3; in_valid = 1'b1;
    #1;
    check("mul in_ready", in_ready, 1);
    tick;
    funct = 11'b10001011000; a = '1; b = '1;
    cnt = 0;
    for (int c = 1; c <= N; c++) begin
      if (!in_ready && !out_valid) cnt++;
      if (c == N) in_valid = 1'b0;
      tick;
    end
    check("mul busy cycles", cnt, N);
    check("mul out_valid", out_valid, 1);
    check("mul result", result, 64'h3_0000_0003);
    check("mul zero", zero, 0);
    check("mul illegal", illegal, 0);
    tick;

    // Reset on cycle 20 of a multiply
    funct = 11'b10011011000; a = 64'd5; b = 64'd6; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (19) tick;
    check("mulrst busy", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("mulrst out_valid", out_valid, 0);
    check("mulrst result", result, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("mulrst in_ready", in_ready, 1);
    cnt = 0;
    for (int c = 0; c < 2 * N; c++) begin
      if (out_valid) cnt++;
      tick;
    end
    check("mulrst no result", cnt, 0);
`else
    // Multiply disabled: illegal at latency 1
    out_ready = 1'b1; aluop = 2'b10; funct = 11'b10011011000;
    a = 64'd6; b = 64'd7; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("nomul out_valid", out_valid, 1);
    check("nomul illegal", illegal, 1);
    check("nomul result", result, 0);
    check("nomul zero", zero, 1);
    tick;
`endif

    // Randomized traffic against the reference model
    pushes = 0; pops = 0; spurious = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      aluop     = 2'($urandom_range(0, 3));
      funct     = ($urandom_range(0, 4) == 0) ? 11'($urandom) : fl[$urandom_range(0, 7)];
      a         = {$urandom, $urandom};
      b         = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) spurious++;
        else begin
          e = q.pop_front();
          pops++;
          check($sformatf("rand%0d", cyc), {result, zero, illegal}, e);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(aluop, funct, a, b));
        pushes++;
      end
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4 * N && q.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        pops++;
        check("rand drain", {result, zero, illegal}, e);
      end
      tick;
    end
    check("rand pops", pops, pushes);
    check("rand spurious", spurious, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_alu_unit.md
EXEC_ALU_UNIT -- requirements
Module: exec_alu_unit

Interface
REQ-001 SHALL have parameter N, default 64, datapath width in bits (legal values 8, 16, 32, 64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port funct  input  11  instruction opcode field.
REQ-007 SHALL have port aluop  input  2  main-decoder ALU class.
REQ-008 SHALL have ports a, b  input  N  operands.
REQ-009 SHALL have port out_valid  output  1  result, zero and illegal are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  N  registered result.
REQ-012 SHALL have port zero  output  1  set when result == 0.
REQ-013 SHALL have port illegal  output  1  request decoded to no supported operation.

Function
REQ-014 SHALL accept a request when in_valid and in_ready are both high on a rising edge, capturing funct, aluop, a and b.
REQ-015 SHALL decode the operation as follows, first match wins.
- aluop=00: ADD.
- aluop=01 with funct[10:3]=10110100 (CBZ) or 10110101 (CBNZ): PASS b.
- aluop=1x: 10001011000 ADD; 11001011000 SUB; 10001010000 AND; 10101010000 ORR; funct[10:1]=1001000100 ADD (ADDI); 10011011000 MUL.
- Anything else: illegal=1, result=0.
REQ-016 SHALL compute ADD/SUB modulo 2^N with carry and borrow discarded; MUL SHALL yield the low N bits of a*b.
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-018 SHALL, for a non-MUL request, go from IDLE or DONE to DONE with the result registered, so out_valid rises on the cycle after accept (latency 1).
REQ-019 SHALL, for MUL, enter BUSY and run an iterative shift-add for exactly N cycles, then enter DONE (latency N+1); in_ready SHALL be 0 throughout BUSY.
REQ-020 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready), so back-to-back single-cycle operations sustain one result per cycle.
REQ-021 SHALL hold result, zero and illegal stable in DONE while out_ready=0.
REQ-022 SHALL go from DONE to IDLE when out_ready=1 and no new request is accepted; on a simultaneous accept it SHALL follow REQ-018/REQ-019.
REQ-023 SHALL ignore in_valid while in BUSY; funct, a and b changes during BUSY SHALL NOT affect the result.
REQ-024 SHALL compute zero from the registered result, including PASS and illegal (illegal implies zero=1).

Reset
REQ-025 SHALL, on reset assertion at any time (including mid-BUSY), immediately force state=IDLE, result=0, zero=0, illegal=0, out_valid=0, and clear the multiply counter and accumulator.
REQ-026 SHALL discard any in-flight operation on reset, with no result emitted after reset release.
REQ-027 SHALL drive in_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-028 SHALL compile in the MUL path (BUSY state, counter, accumulator) only when macro EXEC_ALU_MUL_EN is defined.
REQ-029 SHALL, without EXEC_ALU_MUL_EN, decode funct 10011011000 as illegal with latency 1, never enter BUSY, and otherwise behave identically.

Verification
REQ-030 SHALL cover: N=64, aluop=10, funct=11001011000, a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=0xFFFFFFFFFFFFFFFE, zero=0.
REQ-031 SHALL cover: aluop=01, funct=10110100000, a=9, b=0 -> result=0, zero=1, illegal=0; then funct=10110101xxx, b=3 -> result=3, zero=0.
REQ-032 SHALL cover: EXEC_ALU_MUL_EN defined, MUL a=0x1_0000_0001, b=0x3 -> in_ready=0 for 64 cycles, out_valid on cycle 65 with result=0x3_0000_0003.
REQ-033 SHALL cover: four back-to-back ADDs with out_ready=1 -> four consecutive out_valid cycles; with out_ready held 0 -> first result held stable and in_ready=0.
REQ-034 SHALL cover: reset asserted on cycle 20 of a MUL -> outputs cleared asynchronously, no out_valid afterwards, in_ready=1 after release.
REQ-035 SHALL cover: aluop=10, funct=11111111111 -> illegal=1, result=0, zero=1; and MUL without EXEC_ALU_MUL_EN -> illegal=1 at latency 1.
